// File: rtl/axi_slave_pipeline_if.sv
// Bus response codes and the AXI-Lite-style channel bundle shared by
// masters and the axi_slave_pipeline front end.
package BusPack;
  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_t;
endpackage

interface Axi_ift #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic                      aw_valid;
  logic                      aw_ready;
  logic [ADDR_WIDTH-1:0]     aw_addr;
  logic                      w_valid;
  logic                      w_ready;
  logic [DATA_WIDTH-1:0]     w_data;
  logic [DATA_WIDTH/8-1:0]   w_strb;
  logic                      b_valid;
  logic                      b_ready;
  BusPack::resp_t            b_resp;
  logic                      ar_valid;
  logic                      ar_ready;
  logic [ADDR_WIDTH-1:0]     ar_addr;
  logic                      r_valid;
  logic                      r_ready;
  logic [DATA_WIDTH-1:0]     r_data;
  BusPack::resp_t            r_resp;

  modport Slave (
    input  aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
           ar_valid, ar_addr, r_ready,
    output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );

  modport Master (
    output aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
           ar_valid, ar_addr, r_ready,
    input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );
endinterface

// File: rtl/axi_slave_pipeline.sv
// Single-beat AXI-Lite slave front end: independent write and read FSMs that
// convert bus handshakes into one-cycle strobes on a registered backend port.
module axi_slave_pipeline #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rstn,
  Axi_ift.Slave                   mem_ift,
  output logic                    mem_wen,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [ADDR_WIDTH-1:0]   mem_waddr,
  input  BusPack::resp_t          mem_bresp,
  output logic                    mem_ren,
  output logic [ADDR_WIDTH-1:0]   mem_raddr,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  BusPack::resp_t          mem_rresp
);
  import BusPack::*;

  typedef enum logic [1:0] {W_IDLE, W_MEM, W_WAIT, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_MEM, R_WAIT, R_RESP} rstate_t;

  wstate_t w_state_reg;
  rstate_t r_state_reg;
  logic    aw_done_reg, w_done_reg;
  logic    aw_ready_reg, w_ready_reg, ar_ready_reg;
  logic    b_valid_reg, r_valid_reg;
  resp_t   b_resp_reg, r_resp_reg;
  logic [DATA_WIDTH-1:0] r_data_reg;

  logic aw_hs, w_hs, ar_hs;

  // Readies are registers, so handshakes never loop back through a valid input.
  assign aw_hs = mem_ift.aw_valid & aw_ready_reg;
  assign w_hs  = mem_ift.w_valid  & w_ready_reg;
  assign ar_hs = mem_ift.ar_valid & ar_ready_reg;

  assign mem_ift.aw_ready = aw_ready_reg;
  assign mem_ift.w_ready  = w_ready_reg;
  assign mem_ift.b_valid  = b_valid_reg;
  assign mem_ift.b_resp   = b_resp_reg;
  assign mem_ift.ar_ready = ar_ready_reg;
  assign mem_ift.r_valid  = r_valid_reg;
  assign mem_ift.r_data   = r_data_reg;
  assign mem_ift.r_resp   = r_resp_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state_reg  <= W_IDLE;
      aw_done_reg  <= 1'b0;
      w_done_reg   <= 1'b0;
      aw_ready_reg <= 1'b1;
      w_ready_reg  <= 1'b1;
      mem_wen      <= 1'b0;
      b_valid_reg  <= 1'b0;
      b_resp_reg   <= OKAY;
      mem_waddr    <= '0;
      mem_wdata    <= '0;
      mem_wmask    <= '0;
    end else begin
      case (w_state_reg)
        W_IDLE: begin
          if (aw_hs) begin
            mem_waddr    <= mem_ift.aw_addr;
            aw_done_reg  <= 1'b1;
            aw_ready_reg <= 1'b0;
          end
          if (w_hs) begin
            mem_wdata   <= mem_ift.w_data;
            mem_wmask   <= mem_ift.w_strb;
            w_done_reg  <= 1'b1;
            w_ready_reg <= 1'b0;
          end
          // AW and W may arrive together or in either order.
          if ((aw_done_reg | aw_hs) && (w_done_reg | w_hs)) begin
            aw_ready_reg <= 1'b0;
            w_ready_reg  <= 1'b0;
            mem_wen      <= 1'b1;
            w_state_reg  <= W_MEM;
          end
        end
        W_MEM: begin
          mem_wen     <= 1'b0;
          w_state_reg <= W_WAIT;
        end
        W_WAIT: begin
          b_resp_reg  <= mem_bresp;
          b_valid_reg <= 1'b1;
          w_state_reg <= W_RESP;
        end
        W_RESP: begin
          if (mem_ift.b_ready) begin
            b_valid_reg  <= 1'b0;
            aw_done_reg  <= 1'b0;
            w_done_reg   <= 1'b0;
            aw_ready_reg <= 1'b1;
            w_ready_reg  <= 1'b1;
            w_state_reg  <= W_IDLE;
          end
        end
        default: w_state_reg <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state_reg  <= R_IDLE;
      ar_ready_reg <= 1'b1;
      mem_ren      <= 1'b0;
      r_valid_reg  <= 1'b0;
      r_data_reg   <= '0;
      r_resp_reg   <= OKAY;
      mem_raddr    <= '0;
    end else begin
      case (r_state_reg)
        R_IDLE: begin
          if (ar_hs) begin
            mem_raddr    <= mem_ift.ar_addr;
            ar_ready_reg <= 1'b0;
            mem_ren      <= 1'b1;
            r_state_reg  <= R_MEM;
          end
        end
        R_MEM: begin
          mem_ren     <= 1'b0;
          r_state_reg <= R_WAIT;
        end
        R_WAIT: begin
          r_data_reg  <= mem_rdata;
          r_resp_reg  <= mem_rresp;
          r_valid_reg <= 1'b1;
          r_state_reg <= R_RESP;
        end
        R_RESP: begin
          if (mem_ift.r_ready) begin
            r_valid_reg  <= 1'b0;
            ar_ready_reg <= 1'b1;
            r_state_reg  <= R_IDLE;
          end
        end
        default: r_state_reg <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_slave_pipeline.sv
// Scenario bench for axi_slave_pipeline: bench-side backend model, scoreboard
// queues filled at stimulus time and drained when the DUT emits activity.
module tb_axi_slave_pipeline;
  import BusPack::*;

  localparam int AW = 64;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  Axi_ift #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  logic            mem_wen, mem_ren;
  logic [DW/8-1:0] mem_wmask;
  logic [DW-1:0]   mem_wdata, mem_rdata;
  logic [AW-1:0]   mem_waddr, mem_raddr;
  resp_t           mem_bresp, mem_rresp;

  axi_slave_pipeline #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .mem_ift   (bus),
    .mem_wen   (mem_wen),
    .mem_wmask (mem_wmask),
    .mem_wdata (mem_wdata),
    .mem_waddr (mem_waddr),
    .mem_bresp (mem_bresp),
    .mem_ren   (mem_ren),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .mem_rresp (mem_rresp)
  );

  int errors = 0;
  int checks = 0;

  // Backend model: registers its response on the edge that ends the strobe.
  resp_t         be_bresp = OKAY, be_rresp = OKAY;
  logic [DW-1:0] be_rdata = '0;
  always @(posedge clk) begin
    if (mem_wen) mem_bresp <= be_bresp;
    if (mem_ren) begin
      mem_rdata <= be_rdata;
      mem_rresp <= be_rresp;
    end
  end

  typedef struct {
    logic [AW-1:0]   addr;
    logic [DW-1:0]   data;
    logic [DW/8-1:0] mask;
  } wexp_t;
  typedef struct {
    logic [DW-1:0] data;
    resp_t         resp;
  } rexp_t;

  wexp_t exp_w[$];
  resp_t exp_b[$];
  rexp_t exp_r[$];

  // Monitor samples just before each rising edge, when inputs and outputs are settled.
  always @(negedge clk) begin
    #4;
    if (rstn) begin
      if (mem_wen) begin
        checks++;
        if (exp_w.size() == 0) begin
          errors++; $display("FAIL sb_wen: unexpected mem_wen addr=%0h", mem_waddr);
        end else begin
          wexp_t e;
          e = exp_w.pop_front();
          if (mem_waddr !== e.addr || mem_wdata !== e.data || mem_wmask !== e.mask) begin
            errors++;
            $display("FAIL sb_wen: got addr=%0h data=%0h mask=%0h want addr=%0h data=%0h mask=%0h",
                     mem_waddr, mem_wdata, mem_wmask, e.addr, e.data, e.mask);
          end
        end
      end
      if (bus.b_valid && exp_b.size() == 0) begin
        checks++; errors++; $display("FAIL sb_b: unexpected b_valid resp=%0d", bus.b_resp);
      end else if (bus.b_valid && bus.b_ready) begin
        resp_t e;
        e = exp_b.pop_front();
        checks++;
        if (bus.b_resp !== e) begin
          errors++; $display("FAIL sb_b: got b_resp=%0d want %0d", bus.b_resp, e);
        end
      end
      if (bus.r_valid && exp_r.size() == 0) begin
        checks++; errors++; $display("FAIL sb_r: unexpected r_valid data=%0h", bus.r_data);
      end else if (bus.r_valid && bus.r_ready) begin
        rexp_t e;
        e = exp_r.pop_front();
        checks++;
        if (bus.r_data !== e.data || bus.r_resp !== e.resp) begin
          errors++;
          $display("FAIL sb_r: got data=%0h resp=%0d want data=%0h resp=%0d",
                   bus.r_data, bus.r_resp, e.data, e.resp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // W handshakes in cycle 0, AW in cycle aw_dly; B accepted bready_dly cycles after b_valid.
  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [DW/8-1:0] strb, input resp_t resp,
                          input int aw_dly, input int bready_dly);
    int c;
    be_bresp = resp;
    exp_w.push_back('{addr: addr, data: data, mask: strb});
    exp_b.push_back(resp);
    for (c = 0; c <= aw_dly + 3 + bready_dly + 1; c++) begin
      @(negedge clk);
      if (c == 0) chk("w_ready_idle", {63'd0, bus.w_ready}, 64'd1);
      if (c > 0 && c <= aw_dly) chk("w_ready_after_w", {63'd0, bus.w_ready}, 64'd0);
      if (c == aw_dly) chk("aw_ready_idle", {63'd0, bus.aw_ready}, 64'd1);
      if (c == aw_dly + 1) begin
        chk("wen_high", {63'd0, mem_wen}, 64'd1);
        chk("waddr", mem_waddr, addr);
        chk("wdata", mem_wdata, data);
        chk("aw_ready_busy", {63'd0, bus.aw_ready}, 64'd0);
      end else begin
        chk("wen_low", {63'd0, mem_wen}, 64'd0);
      end
      if (c == aw_dly + 2) chk("b_valid_early", {63'd0, bus.b_valid}, 64'd0);
      if (c >= aw_dly + 3 && c <= aw_dly + 3 + bready_dly) begin
        chk("b_valid", {63'd0, bus.b_valid}, 64'd1);
        chk("b_resp_hold", {62'd0, bus.b_resp}, {62'd0, resp});
      end
      if (c == aw_dly + 4 + bready_dly) begin
        chk("b_valid_drop", {63'd0, bus.b_valid}, 64'd0);
        chk("aw_ready_back", {63'd0, bus.aw_ready}, 64'd1);
      end
      bus.w_valid  = (c == 0);
      bus.w_data   = data;
      bus.w_strb   = strb;
      bus.aw_valid = (c == aw_dly);
      bus.aw_addr  = addr;
      bus.b_ready  = (c == aw_dly + 3 + bready_dly);
    end
    bus.b_ready = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input resp_t resp, input int rready_dly);
    int c;
    be_rdata = data;
    be_rresp = resp;
    exp_r.push_back('{data: data, resp: resp});
    for (c = 0; c <= 3 + rready_dly + 1; c++) begin
      @(negedge clk);
      if (c == 0) chk("ar_ready_idle", {63'd0, bus.ar_ready}, 64'd1);
      if (c == 1) begin
        chk("ren_high", {63'd0, mem_ren}, 64'd1);
        chk("raddr", mem_raddr, addr);
      end else begin
        chk("ren_low", {63'd0, mem_ren}, 64'd0);
      end
      if (c == 2) chk("r_valid_early", {63'd0, bus.r_valid}, 64'd0);
      if (c >= 1 && c <= 3 + rready_dly) chk("ar_ready_busy", {63'd0, bus.ar_ready}, 64'd0);
      if (c >= 3 && c <= 3 + rready_dly) begin
        chk("r_valid", {63'd0, bus.r_valid}, 64'd1);
        chk("r_data_hold", bus.r_data, data);
      end
      if (c == 4 + rready_dly) begin
        chk("r_valid_drop", {63'd0, bus.r_valid}, 64'd0);
        chk("ar_ready_back", {63'd0, bus.ar_ready}, 64'd1);
      end
      bus.ar_valid = (c == 0);
      bus.ar_addr  = addr;
      bus.r_ready  = (c == 3 + rready_dly);
    end
    bus.r_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_aw_ready", {63'd0, bus.aw_ready}, 64'd1);
    chk("rst_w_ready", {63'd0, bus.w_ready}, 64'd1);
    chk("rst_ar_ready", {63'd0, bus.ar_ready}, 64'd1);
    chk("rst_strobes", {62'd0, mem_wen, mem_ren}, 64'd0);
    chk("rst_valids", {62'd0, bus.b_valid, bus.r_valid}, 64'd0);
    chk("rst_waddr", mem_waddr, 64'd0);
    chk("rst_wdata", mem_wdata, 64'd0);
    chk("rst_wmask", {56'd0, mem_wmask}, 64'd0);
    chk("rst_raddr", mem_raddr, 64'd0);
    chk("rst_rdata", bus.r_data, 64'd0);
    chk("rst_resps", {60'd0, bus.b_resp, bus.r_resp}, 64'd0);
    rstn = 1'b1;
  endtask

  task automatic test_basic_write();
    do_write(64'h8, 64'h1234, 8'hFF, OKAY, 0, 0);
  endtask

  task automatic test_split_write();
    do_write(64'h10, 64'hA5A5_0000_5A5A, 8'h0F, SLVERR, 4, 2);
  endtask

  task automatic test_read_backpressure();
    do_read(64'h18, 64'hDEADBEEF, OKAY, 5);
  endtask

  task automatic test_concurrent();
    fork
      do_write(64'h20, 64'h1111_2222_3333_4444, 8'hC3, EXOKAY, 0, 0);
      do_read(64'h28, 64'h5555_6666_7777_8888, DECERR, 0);
    join
  endtask

  task automatic test_reset_mid();
    exp_w.push_back('{addr: 64'h30, data: 64'h77, mask: 8'h01});
    be_bresp = OKAY;
    @(negedge clk);
    bus.aw_valid = 1'b1; bus.aw_addr = 64'h30;
    bus.w_valid  = 1'b1; bus.w_data  = 64'h77; bus.w_strb = 8'h01;
    @(negedge clk);
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    chk("mid_wen", {63'd0, mem_wen}, 64'd1);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("mid_aw_ready", {63'd0, bus.aw_ready}, 64'd1);
    chk("mid_w_ready", {63'd0, bus.w_ready}, 64'd1);
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("mid_no_b", {63'd0, bus.b_valid}, 64'd0);
      chk("mid_no_wen", {63'd0, mem_wen}, 64'd0);
      chk("mid_readies", {61'd0, bus.aw_ready, bus.w_ready, bus.ar_ready}, 64'd7);
    end
    do_write(64'h38, 64'hCAFE, 8'h3C, DECERR, 0, 1);
  endtask

  initial begin
    bus.aw_valid = 1'b0; bus.aw_addr = '0;
    bus.w_valid  = 1'b0; bus.w_data  = '0; bus.w_strb = '0;
    bus.b_ready  = 1'b0;
    bus.ar_valid = 1'b0; bus.ar_addr = '0;
    bus.r_ready  = 1'b0;
    test_reset();
    test_basic_write();
    test_split_write();
    test_read_backpressure();
    test_concurrent();
    test_reset_mid();
    repeat (2) @(negedge clk);
    chk("sb_drained", 64'(exp_w.size() + exp_b.size() + exp_r.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
